// File: rtl/hub75_scan_seq.sv
`timescale 1ns/1ps
// HUB75 row/bit-plane scan sequencer.
// Walks every (row, plane) pair. Each pair is shifted in, latched onto the
// panel while it is blanked, and then shown for a time set by the plane
// weight. The next shift overlaps the current display.
//
// Handshake: a *_go output is a one-cycle request. It may only be issued
// while the matching *_rdy input is high. The target drops *_rdy in the
// following cycle and raises it again when done. Ready inputs are ignored
// in the cycle right after any go pulse, which covers a target that drops
// rdy one cycle late.
module hub75_scan_seq #(
   parameter int N_ROWS     = 32,
   parameter int N_PLANES   = 8,
   parameter int LOG_N_ROWS = $clog2(N_ROWS),
   localparam int PW        = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ctrl_run,
   output logic                  stat_frame,
   output logic [LOG_N_ROWS-1:0] shift_row,
   output logic [PW-1:0]         shift_plane,
   output logic                  shift_go,
   input  logic                  shift_rdy,
   output logic [N_PLANES-1:0]   blank_plane,
   output logic                  blank_go,
   input  logic                  blank_rdy,
   output logic [LOG_N_ROWS-1:0] phy_addr,
   output logic                  phy_le,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_WAIT  = 3'd2,
      S_LATCH = 3'd3,
      S_GO    = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   localparam logic [LOG_N_ROWS-1:0] LAST_ROW   = LOG_N_ROWS'(N_ROWS - 1);
   localparam logic [PW-1:0]         LAST_PLANE = PW'(N_PLANES - 1);
   localparam logic [N_PLANES-1:0]   ONE_HOT0   = N_PLANES'(1);

   state_t                  state_q, state_d;
   logic [LOG_N_ROWS-1:0]   row_q, row_d;
   logic [PW-1:0]           plane_q, plane_d;
   logic                    ign_q, ign_d;
   logic [LOG_N_ROWS-1:0]   shift_row_q, shift_row_d;
   logic [PW-1:0]           shift_plane_q, shift_plane_d;
   logic [N_PLANES-1:0]     blank_plane_q, blank_plane_d;
   logic [LOG_N_ROWS-1:0]   phy_addr_q, phy_addr_d;
   logic                    phy_le_q, phy_le_d;
   logic                    shift_go_c, blank_go_c;

   // Next-state, counter advance and request generation.
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      plane_d       = plane_q;
      blank_plane_d = blank_plane_q;
      phy_addr_d    = phy_addr_q;
      phy_le_d      = 1'b0;
      shift_go_c    = 1'b0;
      blank_go_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctrl_run && shift_rdy && blank_rdy) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            shift_go_c = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // Latch only with the shifter done and the panel blanked.
            if (!ign_q && shift_rdy && blank_rdy) begin
               state_d    = S_LATCH;
               phy_le_d   = 1'b1;
               phy_addr_d = row_q;
            end
         end
         S_LATCH: begin
            blank_plane_d = ONE_HOT0 << plane_q;
            if (plane_q == LAST_PLANE) begin
               plane_d = '0;
               row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
               plane_d = plane_q + 1'b1;
            end
            state_d = S_GO;
         end
         S_GO: begin
            blank_go_c = 1'b1;
            if (ctrl_run) begin
               shift_go_c = 1'b1;
               state_d    = S_WAIT;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!ign_q && blank_rdy) begin
               state_d = S_IDLE;
               row_d   = '0;
               plane_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ign_d         = shift_go_c | blank_go_c;
      shift_row_d   = shift_go_c ? row_q   : shift_row_q;
      shift_plane_d = shift_go_c ? plane_q : shift_plane_q;
   end

   // State, counters and held output values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         plane_q       <= '0;
         ign_q         <= 1'b0;
         shift_row_q   <= '0;
         shift_plane_q <= '0;
         blank_plane_q <= '0;
         phy_addr_q    <= '0;
         phy_le_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         plane_q       <= plane_d;
         ign_q         <= ign_d;
         shift_row_q   <= shift_row_d;
         shift_plane_q <= shift_plane_d;
         blank_plane_q <= blank_plane_d;
         phy_addr_q    <= phy_addr_d;
         phy_le_q      <= phy_le_d;
      end
   end

   // The LATCH cycle still holds the pre-advance counters.
   assign stat_frame  = (state_q == S_LATCH) && (row_q == LAST_ROW) &&
                        (plane_q == LAST_PLANE);
   assign shift_go    = shift_go_c;
   assign blank_go    = blank_go_c;
   assign shift_row   = shift_row_d;
   assign shift_plane = shift_plane_d;
   assign blank_plane = blank_plane_q;
   assign phy_addr    = phy_addr_q;
   assign phy_le      = phy_le_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_hub75_scan_seq.sv
`timescale 1ns/1ps
// Bench for hub75_scan_seq with 4 rows and 2 planes. The shifter is busy
// for 5 cycles and the blanking stage for 3 x weight cycles (20 when slow).
module tb_hub75_scan_seq;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd2;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       ctrl_run = 1'b0;
   logic       shift_rdy = 1'b1;
   logic       blank_rdy = 1'b1;
   logic       stat_frame, shift_go, blank_go, phy_le;
   logic [1:0] shift_row, phy_addr, blank_plane;
   logic       shift_plane;
   logic [2:0] dbg_state;

   hub75_scan_seq #(.N_ROWS(4), .N_PLANES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_run(ctrl_run),
      .stat_frame(stat_frame), .shift_row(shift_row),
      .shift_plane(shift_plane), .shift_go(shift_go), .shift_rdy(shift_rdy),
      .blank_plane(blank_plane), .blank_go(blank_go), .blank_rdy(blank_rdy),
      .phy_addr(phy_addr), .phy_le(phy_le), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int shift_cnt = 0, le_cnt = 0, bgo_cnt = 0, frame_cnt = 0;
   bit no_shift_exp = 1'b0;
   bit blank_slow = 1'b0;
   logic [1:0] m_row = '0;
   logic       m_plane = 1'b0;
   logic [2:0] lat_exp_q[$];
   logic [1:0] blk_exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stat_frame"}, stat_frame, 0);
      chk({tag, "_shift_row"}, shift_row, 0);
      chk({tag, "_shift_plane"}, shift_plane, 0);
      chk({tag, "_shift_go"}, shift_go, 0);
      chk({tag, "_blank_plane"}, blank_plane, 0);
      chk({tag, "_blank_go"}, blank_go, 0);
      chk({tag, "_phy_addr"}, phy_addr, 0);
      chk({tag, "_phy_le"}, phy_le, 0);
      chk({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // driver tasks: inputs change 1 time unit after the active edge
   task automatic drive_run(input logic v);
      @(posedge clk); #1 ctrl_run = v;
   endtask

   task automatic wait_le_cnt(input int n, input int budget, input string tag);
      int i = 0;
      while (le_cnt < n && i < budget) begin @(negedge clk); i++; end
      chk(tag, (le_cnt >= n), 1);
   endtask

   task automatic wait_le_pulse(input int budget, input string tag);
      int i = 0;
      do begin @(negedge clk); i++; end while (!phy_le && i < budget);
      chk(tag, phy_le, 1);
   endtask

   task automatic wait_shift(input int budget, input string tag);
      int i = 0;
      do begin @(negedge clk); i++; end while (!shift_go && i < budget);
      chk(tag, shift_go, 1);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int i = 0;
      do begin @(negedge clk); i++; end while (dbg_state != s && i < budget);
      chk(tag, dbg_state, s);
   endtask

   // shifter model: rdy low for 5 cycles starting the cycle after shift_go
   initial begin : shifter_model
      int cnt = 0;
      bit sgo;
      forever begin
         @(negedge clk); sgo = shift_go;
         @(posedge clk); #1;
         if (sgo) cnt = 5;
         else if (cnt > 0) cnt--;
         shift_rdy = (cnt == 0);
      end
   end

   // blanking model: rdy low for 3 x weight cycles (or 20 when slow)
   initial begin : blank_model
      int cnt = 0;
      bit bgo;
      logic [1:0] w;
      forever begin
         @(negedge clk); bgo = blank_go; w = blank_plane;
         @(posedge clk); #1;
         if (bgo) cnt = blank_slow ? 20 : 3 * int'(w);
         else if (cnt > 0) cnt--;
         blank_rdy = (cnt == 0);
      end
   end

   // scoreboard: shift_go pushes the expected latch, phy_le pops it and
   // pushes the expected display weight, blank_go pops that
   initial begin : monitor
      logic [2:0] e;
      logic [1:0] eb;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (shift_go) begin
               shift_cnt++;
               if (no_shift_exp) chk("no_shift_after_stop", shift_go, 0);
               else begin
                  chk("shift_row", shift_row, m_row);
                  chk("shift_plane", shift_plane, m_plane);
                  lat_exp_q.push_back({m_row, m_plane});
                  {m_row, m_plane} = {m_row, m_plane} + 3'd1;
               end
            end
            if (stat_frame) frame_cnt++;
            if (phy_le) begin
               le_cnt++;
               chk("le_blank_rdy", blank_rdy, 1);
               chk("le_shift_rdy", shift_rdy, 1);
               if (lat_exp_q.size() == 0) chk("le_unexpected", phy_le, 0);
               else begin
                  e = lat_exp_q.pop_front();
                  chk("phy_addr", phy_addr, e[2:1]);
                  chk("stat_frame", stat_frame, (e == 3'b111));
                  blk_exp_q.push_back(e[0] ? 2'b10 : 2'b01);
               end
            end else if (stat_frame) begin
               chk("frame_without_le", stat_frame, 0);
            end
            if (blank_go) begin
               bgo_cnt++;
               if (blk_exp_q.size() == 0) chk("blank_unexpected", blank_go, 0);
               else begin
                  eb = blk_exp_q.pop_front();
                  chk("blank_plane", blank_plane, eb);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base, t0, d, stop_le, stop_bg;
      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", dbg_state, ST_IDLE);

      // startup: shift_go one cycle after run
      drive_run(1'b1);
      @(negedge clk); chk("run_lat_c0", shift_go, 0);
      @(negedge clk); chk("run_lat_c1", shift_go, 1);
      wait_le_pulse(100, "first_le");
      chk("first_phy_addr", phy_addr, 0);
      @(negedge clk);
      chk("start_blank_go", blank_go, 1);
      chk("start_blank_plane", blank_plane, 2'b01);
      chk("start_overlap_go", shift_go, 1);
      chk("start_overlap_row", shift_row, 0);
      chk("start_overlap_plane", shift_plane, 1);

      // full frame plus wrap to (0,0)
      wait_le_cnt(9, 1000, "frame_9_latches");
      chk("frame_pulses", frame_cnt, 1);

      // slow blanking
      blank_slow = 1'b1;
      base = le_cnt; t0 = cyc;
      wait_le_cnt(base + 6, 2000, "slow_latches");
      chk("slow_le_paced", ((cyc - t0) >= 100), 1);
      d = shift_cnt - le_cnt;
      chk("slow_go_balance", (d >= -1 && d <= 1), 1);
      blank_slow = 1'b0;

      // stop anywhere, drain to idle
      drive_run(1'b0);
      wait_state(ST_IDLE, 500, "drain_idle");
      chk("drain_lat_q_empty", lat_exp_q.size(), 0);
      chk("drain_blk_q_empty", blk_exp_q.size(), 0);
      m_row = '0; m_plane = 1'b0;

      // stop during WAIT of (1,0)
      drive_run(1'b1);
      begin
         int i = 0;
         do begin @(negedge clk); i++; end
         while (!(shift_go && shift_row == 2'd1 && shift_plane == 1'b0) && i < 500);
         chk("stop_shift_10_seen", (shift_go && shift_row == 2'd1), 1);
      end
      @(posedge clk); #1;
      ctrl_run = 1'b0; no_shift_exp = 1'b1;
      stop_le = le_cnt; stop_bg = bgo_cnt;
      chk("stop_in_wait", dbg_state, ST_WAIT);
      wait_state(ST_IDLE, 500, "stop_idle");
      chk("stop_idle_blank_rdy", blank_rdy, 1);
      chk("stop_le_count", le_cnt - stop_le, 1);
      chk("stop_bgo_count", bgo_cnt - stop_bg, 1);
      chk("stop_lat_q_empty", lat_exp_q.size(), 0);

      // restart from (0,0)
      @(posedge clk); #1 no_shift_exp = 1'b0;
      m_row = '0; m_plane = 1'b0;
      drive_run(1'b1);
      wait_shift(100, "restart_shift");
      chk("restart_row", shift_row, 0);
      chk("restart_plane", shift_plane, 0);

      // asynchronous reset mid-WAIT
      wait_le_cnt(le_cnt + 2, 500, "pre_reset_latches");
      wait_state(ST_WAIT, 200, "reset_in_wait");
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      lat_exp_q.delete(); blk_exp_q.delete();
      m_row = '0; m_plane = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      wait_shift(100, "post_reset_shift");
      chk("post_reset_row", shift_row, 0);
      chk("post_reset_plane", shift_plane, 0);

      // final drain
      wait_le_cnt(le_cnt + 3, 500, "final_latches");
      drive_run(1'b0);
      wait_state(ST_IDLE, 500, "final_idle");
      chk("final_lat_q_empty", lat_exp_q.size(), 0);
      chk("final_blk_q_empty", blk_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
